// File: rtl/spi_reg_writer.sv
// spi_reg_writer: SPI mode-0 initiator that serialises 16-bit register-write frames MSB-first
module spi_reg_writer #(
   parameter int CLK_DIV = 4,
   parameter int ADDR_W  = 7,
   parameter int DATA_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   output logic              req_ready,
   output logic              busy,
   output logic              done,
   output logic              spi_sclk,
   output logic              spi_copi,
   output logic              spi_ncs
);
   localparam int CW = $clog2(CLK_DIV + 1);
   localparam int FW = 1 + ADDR_W + DATA_W;
   localparam logic [4:0] NBITS = 5'(FW);
   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    bit_q, bit_d;
   logic [FW-1:0] sr_q, sr_d;
   logic          sclk_q, sclk_d, copi_q, copi_d, ncs_q, ncs_d, done_q, done_d;
   logic          tick;
   assign tick      = cnt_q == CW'(CLK_DIV - 1);
   assign req_ready = state_q == IDLE;
   assign busy      = state_q != IDLE;
   assign done      = done_q;
   assign spi_sclk  = sclk_q;
   assign spi_copi  = copi_q;
   assign spi_ncs   = ncs_q;
   // next-state and registered SPI pin values; the trailing low half-period after the last fall precedes HOLD
   always_comb begin
      state_d = state_q;
      cnt_d   = tick ? '0 : cnt_q + 1'b1;
      bit_d   = bit_q;
      sr_d    = sr_q;
      sclk_d  = sclk_q;
      copi_d  = copi_q;
      ncs_d   = ncs_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (req_valid) begin
               state_d = SETUP;
               sr_d    = {1'b1, req_addr, req_data};
               ncs_d   = 1'b0;
               copi_d  = 1'b1;
               bit_d   = '0;
            end
         end
         SETUP: if (tick) begin
            state_d = SHIFT;
            sclk_d  = 1'b1;
            bit_d   = 5'd1;
         end
         SHIFT: if (tick) begin
            if (sclk_q) begin
               sclk_d = 1'b0;
               if (bit_q != NBITS) begin
                  sr_d   = sr_q << 1;
                  copi_d = sr_q[FW-2];
               end
            end else if (bit_q == NBITS) begin
               state_d = HOLD;
            end else begin
               sclk_d = 1'b1;
               bit_d  = bit_q + 5'd1;
            end
         end
         HOLD: if (tick) begin
            state_d = GAP;
            ncs_d   = 1'b1;
            copi_d  = 1'b0;
            done_d  = 1'b1;
         end
         GAP: if (tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // state and output registers; reset forces the SPI pins idle immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sr_q    <= '0;
         sclk_q  <= 1'b0;
         copi_q  <= 1'b0;
         ncs_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sr_q    <= sr_d;
         sclk_q  <= sclk_d;
         copi_q  <= copi_d;
         ncs_q   <= ncs_d;
         done_q  <= done_d;
      end
   end
endmodule

// File: tb/tb_spi_reg_writer.sv
// tb_spi_reg_writer: checks frames, timing and reset abort of spi_reg_writer against a peripheral model
module tb_spi_reg_writer;
   localparam int D = 4;
   logic       clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0;
   logic [6:0] req_addr = '0;
   logic [7:0] req_data = '0;
   logic       req_ready, busy, done, spi_sclk, spi_copi, spi_ncs;
   spi_reg_writer #(.CLK_DIV(D)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .busy(busy), .done(done),
      .spi_sclk(spi_sclk), .spi_copi(spi_copi), .spi_ncs(spi_ncs)
   );
   always #5 clk = ~clk;
   int n_cmp = 0, n_bad = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   typedef struct {logic [15:0] word; int nbits; int low; int gap;} frame_t;
   typedef struct {logic [6:0] a; logic [7:0] d; logic [15:0] w;} vec_t;
   frame_t     fq[$];
   vec_t       tbl[6];
   logic [7:0] periph[128] = '{default: 8'h00};
   logic [7:0] model[128]  = '{default: 8'h00};
   logic       p_sclk = 1'b0, p_ncs = 1'b1, p_copi = 1'b0;
   logic [15:0] sh = '0;
   int         nb = 0, low = 0, high = 1000, gap = 0, viol = 0, done_cnt = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask
   // peripheral-side receiver: samples COPI on SCLK rises, commits only complete 16-bit write frames
   always @(negedge clk) begin
      if (rst_n) begin
         if (p_sclk && spi_sclk && spi_copi !== p_copi) begin viol++; $display("protocol: COPI moved while SCLK high at cycle %0d", cyc); end
         if (spi_ncs !== p_ncs && (spi_sclk || p_sclk)) begin viol++; $display("protocol: nCS moved with SCLK high at cycle %0d", cyc); end
         if (spi_ncs && spi_sclk) begin viol++; $display("protocol: SCLK high with nCS high at cycle %0d", cyc); end
         if (!spi_ncs && req_ready) begin viol++; $display("protocol: req_ready high inside frame at cycle %0d", cyc); end
      end
      if (!p_ncs && spi_ncs) begin
         fq.push_back('{sh, nb, low, gap});
         if (nb == 16 && sh[15]) periph[sh[14:8]] = sh[7:0];
         high = 0;
      end
      if (p_ncs && !spi_ncs) begin
         gap = high; nb = 0; sh = '0; low = 0;
      end
      if (!spi_ncs) begin
         low++;
         if (!p_sclk && spi_sclk) begin sh = {sh[14:0], spi_copi}; nb++; end
      end else high++;
      if (done) done_cnt++;
      p_sclk = spi_sclk; p_ncs = spi_ncs; p_copi = spi_copi;
   end
   task automatic send(input logic [6:0] a, input logic [7:0] d, input bit hold, output int c0);
      int t = 0;
      @(negedge clk);
      req_valid = 1'b1; req_addr = a; req_data = d;
      while (!req_ready && t < 2000) begin @(negedge clk); t++; end
      if (!req_ready) chk("accept_timeout", 0, 1);
      c0 = cyc;
      @(negedge clk);
      req_valid = hold;
      if (!hold) begin req_addr = 7'($urandom); req_data = 8'($urandom); end
   endtask
   task automatic wait_done(input int c0, output int cd);
      int t = 0;
      while (!done && t < 1000) begin @(negedge clk); t++; end
      cd = done ? cyc - c0 : -1;
   endtask
   task automatic wait_ready(input int c0, output int cr);
      int t = 0;
      while (!req_ready && t < 1000) begin @(negedge clk); t++; end
      cr = req_ready ? cyc - c0 : -1;
   endtask
   task automatic check_frame(input string tag, input logic [15:0] w);
      frame_t f;
      chk({tag, "_frame_present"}, fq.size() > 0, 1);
      if (fq.size() > 0) begin
         f = fq.pop_front();
         chk({tag, "_word"}, f.word, w);
         chk({tag, "_nbits"}, f.nbits, 16);
         chk({tag, "_ncs_low"}, f.low, 34 * D);
      end
   endtask
   task automatic write_check(input string tag, input logic [6:0] a, input logic [7:0] d, input logic [15:0] w);
      int c0, cd, cr, dc;
      dc = done_cnt;
      send(a, d, 1'b0, c0);
      wait_done(c0, cd);
      chk({tag, "_done_lat"}, cd, 34 * D + 1);
      @(negedge clk);
      chk({tag, "_done_width"}, done, 0);
      wait_ready(c0, cr);
      chk({tag, "_ready_lat"}, cr, 35 * D + 1);
      chk({tag, "_done_count"}, done_cnt - dc, 1);
      check_frame(tag, w);
      model[a] = d;
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
   initial begin
      int c0, c1, cd, cr, dc, t, m;
      frame_t f;
      logic [6:0] a;
      logic [7:0] d;
      tbl[0] = '{7'h00, 8'hF0, 16'h80F0};
      tbl[1] = '{7'h00, 8'hFF, 16'h80FF};
      tbl[2] = '{7'h02, 8'hFF, 16'h82FF};
      tbl[3] = '{7'h04, 8'h80, 16'h8480};
      tbl[4] = '{7'h7F, 8'h00, 16'hFF00};
      tbl[5] = '{7'h2A, 8'h81, 16'hAA81};
      repeat (3) @(negedge clk);
      chk("rst_ncs", spi_ncs, 1);
      chk("rst_sclk", spi_sclk, 0);
      chk("rst_copi", spi_copi, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_busy_after", busy, 0);
      for (int i = 0; i < 6; i++) write_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].d, tbl[i].w);
      chk("periph_00", periph[0], 8'hFF);
      chk("periph_04", periph[4], 8'h80);
      write_check("clr00", 7'h00, 8'h00, 16'h8000);
      chk("periph_00_clr", periph[0], 8'h00);
      // back-to-back: valid held high across two requests
      send(7'h01, 8'h55, 1'b1, c0);
      req_addr = 7'h02; req_data = 8'hAA;
      wait_ready(c0, cr);
      chk("b2b_ready_lat", cr, 35 * D + 1);
      c1 = cyc;
      @(negedge clk);
      req_valid = 1'b0; req_addr = 7'h55; req_data = 8'h33;
      wait_done(c1, cd);
      chk("b2b_done_lat", cd, 34 * D + 1);
      wait_ready(c1, cr);
      check_frame("b2b0", 16'h8155);
      chk("b2b_gap_ok", fq.size() > 0 ? fq[0].gap >= D : 0, 1);
      check_frame("b2b1", 16'h82AA);
      model[1] = 8'h55; model[2] = 8'hAA;
      // reset asserted at the 8th SCLK rise of a frame
      dc = done_cnt;
      send(7'h10, 8'h3C, 1'b0, c0);
      t = 0;
      while (!(nb == 8 && spi_sclk) && t < 1000) begin @(negedge clk); t++; end
      chk("abort_reached_rise8", nb, 8);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ncs", spi_ncs, 1);
      chk("abort_sclk", spi_sclk, 0);
      chk("abort_copi", spi_copi, 0);
      chk("abort_busy", busy, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4 * D) @(negedge clk);
      chk("abort_no_done", done_cnt - dc, 0);
      chk("abort_frame_present", fq.size() > 0, 1);
      if (fq.size() > 0) begin f = fq.pop_front(); chk("abort_partial_bits", f.nbits, 8); end
      chk("abort_periph_unchanged", periph[7'h10], model[7'h10]);
      write_check("after_abort", 7'h10, 8'h3C, 16'h903C);
      // randomized writes against the register-file model
      for (int i = 0; i < 20; i++) begin
         a = 7'($urandom_range(0, 127));
         d = 8'($urandom);
         write_check($sformatf("rnd%0d", i), a, d, {1'b1, a, d});
      end
      m = 0;
      for (int i = 0; i < 128; i++) if (periph[i] !== model[i]) m++;
      chk("regfile_mismatches", m, 0);
      chk("protocol_violations", viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
